// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: handshake, CON flip-flop and datapath strobe bundle for the branch sequencer
interface branch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       ir_c2;
    logic             con;
    logic             busy;
    logic             done;
    logic             gra;
    logic             r_out;
    logic             con_in;
    logic [1:0]       cond_sel;
    logic             pc_out;
    logic             y_in;
    logic             c_out;
    logic             alu_add;
    logic             z_in;
    logic             zlow_out;
    logic             pc_in;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] nottaken_cnt;

    modport master (
        output start, ir_c2, con,
        input  busy, done, gra, r_out, con_in, cond_sel, pc_out, y_in,
               c_out, alu_add, z_in, zlow_out, pc_in, taken_cnt, nottaken_cnt
    );

    modport slave (
        input  start, ir_c2, con,
        output busy, done, gra, r_out, con_in, cond_sel, pc_out, y_in,
               c_out, alu_add, z_in, zlow_out, pc_in, taken_cnt, nottaken_cnt
    );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: T3..T6 conditional-branch control steps with CON FF handshake and taken/not-taken counters
module branch_sequencer #(
    parameter int CNT_W          = 16,
    parameter bit SKIP_NOT_TAKEN = 1'b0
) (
    input logic               clk,
    input logic               clr,
    branch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cond_sel_q, cond_sel_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

    // State, captured condition, latched CON result and counters; clr aborts everything at once
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q        <= S_IDLE;
            cond_sel_q     <= 2'b00;
            taken_q        <= 1'b0;
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            cond_sel_q     <= cond_sel_d;
            taken_q        <= taken_d;
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    // Next state: start only honoured from IDLE; con sampled at end of T4; counters bumped leaving DONE
    always_comb begin
        state_d        = state_q;
        cond_sel_d     = cond_sel_q;
        taken_d        = taken_q;
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_T3;
                    cond_sel_d = bus.ir_c2;
                end
            end
            S_T3: state_d = S_T4;
            S_T4: begin
                taken_d = bus.con;
                state_d = (SKIP_NOT_TAKEN && !bus.con) ? S_DONE : S_T5;
            end
            S_T5: state_d = S_T6;
            S_T6: state_d = S_DONE;
            S_DONE: begin
                state_d        = S_IDLE;
                taken_cnt_d    = taken_q ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;
                nottaken_cnt_d = taken_q ? nottaken_cnt_q : nottaken_cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobes decoded from the current step; PC load gated by the latched CON result
    always_comb begin
        bus.busy         = state_q != S_IDLE;
        bus.done         = state_q == S_DONE;
        bus.gra          = state_q == S_T3;
        bus.r_out        = state_q == S_T3;
        bus.con_in       = state_q == S_T3;
        bus.pc_out       = state_q == S_T4;
        bus.y_in         = state_q == S_T4;
        bus.c_out        = state_q == S_T5;
        bus.alu_add      = state_q == S_T5;
        bus.z_in         = state_q == S_T5;
        bus.zlow_out     = state_q == S_T6;
        bus.pc_in        = state_q == S_T6 && taken_q;
        bus.cond_sel     = cond_sel_q;
        bus.taken_cnt    = taken_cnt_q;
        bus.nottaken_cnt = nottaken_cnt_q;
    end
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: randomized branch sequences checked against a step-schedule model, with and without not-taken skip
module tb_branch_sequencer;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       con = 1'b0;
    logic [1:0] ir_c2 = 2'b00;
    logic [1:0] cs_exp = 2'b00;
    int         passed = 0;
    int         total = 0;
    int         tk_cnt = 0;
    int         nt_cnt = 0;

    always #5 clk = ~clk;

    branch_sequencer_if #(.CNT_W(W)) if0 ();
    branch_sequencer_if #(.CNT_W(W)) if1 ();

    assign if0.start = start;
    assign if0.ir_c2 = ir_c2;
    assign if0.con   = con;
    assign if1.start = start;
    assign if1.ir_c2 = ir_c2;
    assign if1.con   = con;

    branch_sequencer #(.CNT_W(W), .SKIP_NOT_TAKEN(1'b0)) dut0 (.clk(clk), .clr(clr), .bus(if0));
    branch_sequencer #(.CNT_W(W), .SKIP_NOT_TAKEN(1'b1)) dut1 (.clk(clk), .clr(clr), .bus(if1));

    logic [11:0] v0, v1;
    assign v0 = {if0.busy, if0.done, if0.gra, if0.r_out, if0.con_in, if0.pc_out,
                 if0.y_in, if0.c_out, if0.alu_add, if0.z_in, if0.zlow_out, if0.pc_in};
    assign v1 = {if1.busy, if1.done, if1.gra, if1.r_out, if1.con_in, if1.pc_out,
                 if1.y_in, if1.c_out, if1.alu_add, if1.z_in, if1.zlow_out, if1.pc_in};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k: 1..5 = cycles after the start edge, 0/6 = idle with model counts already current
    task automatic chk_phase(input int k, input bit tk);
        for (int d = 0; d < 2; d++) begin
            int          n;
            int          ph;
            bit          upd;
            logic [11:0] ev;
            logic [11:0] ov;
            logic [1:0]  ocs;
            logic [W-1:0] ot, on;
            n   = (d == 1 && !tk) ? 3 : 5;
            ph  = (k < 1 || k > n) ? 0 : (k == n ? 5 : k);
            upd = k > n && k <= 5;
            ev  = {ph != 0, ph == 5, ph == 1, ph == 1, ph == 1, ph == 2,
                   ph == 2, ph == 3, ph == 3, ph == 3, ph == 4, ph == 4 && tk};
            ov  = d ? v1 : v0;
            ocs = d ? if1.cond_sel : if0.cond_sel;
            ot  = d ? if1.taken_cnt : if0.taken_cnt;
            on  = d ? if1.nottaken_cnt : if0.nottaken_cnt;
            chk($sformatf("strobes d%0d k%0d", d, k), 32'(ov), 32'(ev));
            chk($sformatf("cond_sel d%0d k%0d", d, k), 32'(ocs), 32'(cs_exp));
            chk($sformatf("taken_cnt d%0d k%0d", d, k), 32'(ot),
                (tk_cnt + ((upd && tk) ? 1 : 0)) % (1 << W));
            chk($sformatf("nottaken_cnt d%0d k%0d", d, k), 32'(on),
                (nt_cnt + ((upd && !tk) ? 1 : 0)) % (1 << W));
        end
    endtask

    task automatic txn(input logic [1:0] c2, input bit tk, input int glitch_k);
        start = 1'b1;
        ir_c2 = c2;
        con   = 1'($urandom);
        tick();
        start  = 1'b0;
        ir_c2  = 2'($urandom);
        cs_exp = c2;
        for (int k = 1; k <= 5; k++) begin
            chk_phase(k, tk);
            con = (k == 2) ? tk : 1'($urandom);
            if (k == glitch_k) begin
                start = 1'b1;
                ir_c2 = 2'b10;
            end
            tick();
            start = 1'b0;
        end
        if (tk) tk_cnt++;
        else nt_cnt++;
        chk_phase(6, tk);
    endtask

    initial begin
        tick();
        tick();
        chk_phase(0, 1'b0);
        clr = 1'b1;
        tick();
        chk_phase(0, 1'b0);
        txn(2'b00, 1'b1, 0);
        txn(2'b11, 1'b0, 0);
        txn(2'b01, 1'b1, 2);
        txn(2'b10, 1'b0, 2);
        txn(2'b01, 1'b1, 5);
        start = 1'b1;
        ir_c2 = 2'b11;
        con   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 clr = 1'b0;
        #1;
        tk_cnt = 0;
        nt_cnt = 0;
        cs_exp = 2'b00;
        chk_phase(0, 1'b0);
        tick();
        clr = 1'b1;
        tick();
        chk_phase(0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            bit tk;
            tk = 1'($urandom);
            txn(2'($urandom), tk, tk ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < (1 << W) + 1; i++) txn(2'($urandom), 1'b1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
